// File: rtl/xmodem_receiver_if.sv
// Byte link toward the XMODEM sender plus the payload write port of the receiver.
// master = receiver side, slave = UART / payload-memory side.
interface xmodem_receiver_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       wr_en;
  logic [4:0] wr_block;
  logic [6:0] wr_byte;
  logic [7:0] wr_data;
  logic       blk_commit;

  modport master (
    input  rx_byte, rx_valid, tx_ready,
    output tx_byte, tx_valid, wr_en, wr_block, wr_byte, wr_data, blk_commit
  );

  modport slave (
    output rx_byte, rx_valid, tx_ready,
    input  tx_byte, tx_valid, wr_en, wr_block, wr_byte, wr_data, blk_commit
  );
endinterface

// File: rtl/xmodem_receiver.sv
// XMODEM (checksum) receiver: NAK-initiated handshake, header/checksum validation,
// ACK/NAK/CAN responses and payload streaming into 32 block slots.
module xmodem_receiver #(
  parameter int TIMEOUT   = 1 << 20,
  parameter int MAX_RETRY = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  xmodem_receiver_if.master bus,
  output logic [5:0]        blk_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_NAK, S_WAIT_HDR, S_BLK, S_NBLK,
    S_DATA, S_CSUM, S_RESP, S_FINISH, S_ABORT
  } state_t;

  state_t          state, state_nxt, resp_to, resp_q;
  logic [7:0]      blk, nblk, expected, sum, tx_code;
  logic [6:0]      byte_idx;
  logic [RW-1:0]   retry;
  logic [TW-1:0]   tmo;
  logic            tx_load, commit, retry_inc, begin_xfer;
  logic            in_window, tmo_hit, hdr_good, is_new, is_dup, sum_ok, room, wr_take;

  assign in_window = state inside {S_WAIT_HDR, S_BLK, S_NBLK, S_DATA, S_CSUM};
  assign tmo_hit   = in_window && !bus.rx_valid && (tmo == TW'(TIMEOUT - 1));
  assign hdr_good  = (blk ^ nblk) == 8'hFF;
  assign is_new    = hdr_good && (blk == expected);
  assign is_dup    = hdr_good && (blk == expected - 8'd1);
  assign sum_ok    = bus.rx_byte == sum;
  assign room      = blk_count < 6'd32;
  assign wr_take   = (state == S_DATA) && bus.rx_valid && is_new && room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_load    = 1'b0;
    tx_code    = ACK;
    resp_to    = S_WAIT_HDR;
    commit     = 1'b0;
    retry_inc  = 1'b0;
    begin_xfer = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        begin_xfer = 1'b1;
        state_nxt  = S_SEND_NAK;
      end
      S_SEND_NAK: begin
        tx_load   = 1'b1;
        state_nxt = S_RESP;
        if (retry == RW'(MAX_RETRY)) begin
          tx_code = CAN;
          resp_to = S_ABORT;
        end else begin
          tx_code   = NAK;
          retry_inc = 1'b1;
        end
      end
      S_WAIT_HDR: if (bus.rx_valid) begin
        case (bus.rx_byte)
          SOH: state_nxt = S_BLK;
          EOT: begin
            tx_load   = 1'b1;
            resp_to   = S_FINISH;
            state_nxt = S_RESP;
          end
          CAN:     state_nxt = S_ABORT;
          default: state_nxt = S_WAIT_HDR;
        endcase
      end
      S_BLK:  if (bus.rx_valid) state_nxt = S_NBLK;
      S_NBLK: if (bus.rx_valid) state_nxt = S_DATA;
      S_DATA: if (bus.rx_valid && byte_idx == 7'd127) state_nxt = S_CSUM;
      S_CSUM: if (bus.rx_valid) begin
        if (is_new && sum_ok && room) begin
          tx_load   = 1'b1;
          commit    = 1'b1;
          state_nxt = S_RESP;
        end else if (is_dup && sum_ok) begin
          tx_load   = 1'b1;
          state_nxt = S_RESP;
        end else if (is_new && sum_ok) begin
          // A 33rd block has nowhere to go: cancel rather than NAK forever.
          tx_load   = 1'b1;
          tx_code   = CAN;
          resp_to   = S_ABORT;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_SEND_NAK;
        end
      end
      S_RESP:   if (bus.tx_valid && bus.tx_ready) state_nxt = resp_q;
      S_FINISH: state_nxt = S_IDLE;
      S_ABORT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Receive states only move on rx_valid, so the timeout can simply override.
    if (tmo_hit) state_nxt = S_SEND_NAK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_byte    <= '0;
      bus.tx_valid   <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_block   <= '0;
      bus.wr_byte    <= '0;
      bus.wr_data    <= '0;
      bus.blk_commit <= 1'b0;
      blk_count      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      resp_q         <= S_WAIT_HDR;
      blk            <= '0;
      nblk           <= '0;
      expected       <= '0;
      sum            <= '0;
      byte_idx       <= '0;
      retry          <= '0;
      tmo            <= '0;
    end else begin
      bus.blk_commit <= commit;
      bus.wr_en      <= wr_take;

      if (tx_load) begin
        bus.tx_valid <= 1'b1;
        bus.tx_byte  <= tx_code;
        resp_q       <= resp_to;
      end else if (bus.tx_valid && bus.tx_ready) begin
        bus.tx_valid <= 1'b0;
      end

      if (!in_window || bus.rx_valid || tmo_hit) tmo <= '0;
      else                                       tmo <= tmo + TW'(1);

      if (begin_xfer) begin
        blk_count <= '0;
        retry     <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
        expected  <= 8'd1;
        busy      <= 1'b1;
      end
      if (retry_inc) retry <= retry + RW'(1);
      if (commit) begin
        blk_count <= blk_count + 6'd1;
        expected  <= expected + 8'd1;
        retry     <= '0;
      end

      case (state)
        S_BLK: if (bus.rx_valid) blk <= bus.rx_byte;
        S_NBLK: if (bus.rx_valid) begin
          nblk     <= bus.rx_byte;
          sum      <= '0;
          byte_idx <= '0;
        end
        S_DATA: if (bus.rx_valid) begin
          sum      <= sum + bus.rx_byte;
          byte_idx <= byte_idx + 7'd1;
          if (wr_take) begin
            bus.wr_data  <= bus.rx_byte;
            bus.wr_byte  <= byte_idx;
            bus.wr_block <= blk_count[4:0];
          end
        end
        S_FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_ABORT: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xmodem_receiver.sv
// Scoreboarded bench for xmodem_receiver: stimulus tasks push expected responses,
// writes and commits from a packet-level model; a negedge monitor pops and compares.
module tb_xmodem_receiver;
  localparam int TMO  = 64;
  localparam int MAXR = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] blk_count;
  logic       busy, done, error;

  xmodem_receiver_if bus();

  xmodem_receiver #(.TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .blk_count(blk_count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] blk;
    logic [6:0] off;
    logic [7:0] data;
  } wr_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ready_mode = 0;  // 0 random, 1 held low, 2 held high
  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  int         exp_commit[$];
  int         tx_times[$];
  logic [7:0] pkt[128];

  // packet-level reference state
  logic [7:0] m_exp;
  int         m_count, m_retry, m_end;  // m_end: 0 running, 1 done, 2 error

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.tx_valid && bus.tx_ready) begin
        tx_times.push_back(cyc);
        if (exp_tx.size() == 0) unexpected("tx_byte", {24'd0, bus.tx_byte});
        else check("tx_byte", {24'd0, bus.tx_byte}, {24'd0, exp_tx.pop_front()});
      end
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) unexpected("wr", {12'd0, bus.wr_block, bus.wr_byte, bus.wr_data});
        else check("wr", {12'd0, bus.wr_block, bus.wr_byte, bus.wr_data}, {12'd0, exp_wr.pop_front()});
      end
      if (bus.blk_commit) begin
        if (exp_commit.size() == 0) unexpected("commit", {27'd0, bus.wr_block});
        else begin
          int idx;
          idx = exp_commit.pop_front();
          check("commit_block", {27'd0, bus.wr_block}, idx);
          check("commit_count", {26'd0, blk_count}, idx + 1);
          check("commit_ack", {23'd0, bus.tx_valid, bus.tx_byte}, {23'd0, 1'b1, 8'h06});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        0:       bus.tx_ready = ($urandom_range(0, 3) != 0);
        1:       bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  task automatic m_start();
    m_count = 0;
    m_retry = 0;
    m_exp   = 8'd1;
    m_end   = 0;
  endtask

  task automatic m_nak();
    if (m_retry == MAXR) begin
      exp_tx.push_back(8'h18);
      m_end = 2;
    end else begin
      exp_tx.push_back(8'h15);
      m_retry++;
    end
  endtask

  task automatic m_packet(input logic [7:0] b, input logic [7:0] nb, input logic [7:0] cs);
    logic [7:0] s;
    logic [7:0] prev;
    bit         hdr_ok, is_new;
    wr_t        w;
    s = 8'h00;
    prev = m_exp - 8'd1;
    for (int i = 0; i < 128; i++) s = s + pkt[i];
    hdr_ok = ((b ^ nb) == 8'hFF);
    is_new = hdr_ok && (b == m_exp);
    if (is_new && m_count < 32)
      for (int i = 0; i < 128; i++) begin
        w.blk = m_count[4:0]; w.off = i[6:0]; w.data = pkt[i];
        exp_wr.push_back(w);
      end
    if (is_new && s == cs && m_count < 32) begin
      exp_tx.push_back(8'h06);
      exp_commit.push_back(m_count);
      m_count++;
      m_exp = m_exp + 8'd1;
      m_retry = 0;
    end else if (hdr_ok && s == cs && b == prev) begin
      exp_tx.push_back(8'h06);
    end else if (is_new && s == cs) begin
      exp_tx.push_back(8'h18);
      m_end = 2;
    end else begin
      m_nak();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check(name, exp_tx.size(), 0);
    exp_tx.delete();
  endtask

  task automatic fill_pkt(input bit rnd);
    for (int i = 0; i < 128; i++) pkt[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic do_start();
    m_start();
    m_nak();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("start_nak");
  endtask

  task automatic send_packet(input logic [7:0] b, input logic [7:0] nb, input bit bad, input bit wait_resp);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 128; i++) cs = cs + pkt[i];
    if (bad) cs = cs + 8'h01;
    m_packet(b, nb, cs);
    send_byte(8'h01);
    send_byte(b);
    send_byte(nb);
    for (int i = 0; i < 128; i++) send_byte(pkt[i]);
    send_byte(cs);
    if (wait_resp) drain("pkt_resp");
  endtask

  task automatic send_eot();
    exp_tx.push_back(8'h06);
    m_end = 1;
    send_byte(8'h04);
    drain("eot_ack");
  endtask

  task automatic finish_check(input string name);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, (m_end == 1) ? 1 : 0);
    check({name, "_error"}, {31'd0, error}, (m_end == 2) ? 1 : 0);
    check({name, "_count"}, {26'd0, blk_count}, m_count);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_commit_left"}, exp_commit.size(), 0);
    exp_wr.delete();
    exp_commit.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         kind;
    logic [7:0] b, nb;
    bit         bad;
    wr_t        w;

    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rst_flags", {26'd0, bus.tx_valid, bus.wr_en, bus.blk_commit, busy, done, error}, 0);
    check("rst_data", {4'd0, bus.tx_byte, bus.wr_block, bus.wr_byte, bus.wr_data}, 0);
    check("rst_count", {26'd0, blk_count}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // silent link: NAK per timeout, then CAN after the retry budget
    ready_mode = 2;
    m_start();
    for (int i = 0; i <= MAXR; i++) m_nak();
    tx_times.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("timeout_resp");
    finish_check("timeout");
    check("timeout_nak_n", tx_times.size(), MAXR + 1);
    for (int i = 1; i < tx_times.size(); i++)
      check("nak_period", ((tx_times[i] - tx_times[i-1]) >= TMO &&
                           (tx_times[i] - tx_times[i-1]) <= TMO + 3) ? 1 : 0, 1);
    ready_mode = 0;

    // two good blocks then EOT
    do_start();
    fill_pkt(0);
    send_packet(8'h01, 8'hFE, 0, 1);
    fill_pkt(1);
    send_packet(8'h02, 8'hFD, 0, 1);
    send_eot();
    finish_check("two_blocks");

    // corrupted checksum, then the retransmission
    do_start();
    fill_pkt(0);
    send_packet(8'h01, 8'hFE, 1, 1);
    send_packet(8'h01, 8'hFE, 0, 1);
    send_eot();
    finish_check("bad_csum");

    // duplicate block and a bad header
    do_start();
    fill_pkt(1);
    send_packet(8'h01, 8'hFE, 0, 1);
    send_packet(8'h01, 8'hFE, 0, 1);
    send_packet(8'h01, 8'hFF, 0, 1);
    send_eot();
    finish_check("dup_hdr");

    // CAN from the sender aborts silently
    do_start();
    m_end = 2;
    send_byte(8'h18);
    finish_check("can_rx");

    // response held off by tx_ready; link bytes meanwhile must be dropped
    do_start();
    ready_mode = 1;
    fill_pkt(1);
    send_packet(8'h01, 8'hFE, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bus.rx_valid = (i % 3 == 0);
      case (i % 4)
        0:       bus.rx_byte = 8'h01;
        1:       bus.rx_byte = 8'h04;
        2:       bus.rx_byte = 8'h18;
        default: bus.rx_byte = 8'($urandom);
      endcase
      @(negedge clk);
      check("stall_tx", {23'd0, bus.tx_valid, bus.tx_byte}, {23'd0, 1'b1, 8'h06});
      tick();
      bus.rx_valid = 1'b0;
    end
    ready_mode = 0;
    drain("stall_release");
    fill_pkt(1);
    send_packet(8'h02, 8'hFD, 0, 1);
    send_eot();
    finish_check("stall");

    // reset in the middle of a data phase
    do_start();
    fill_pkt(1);
    for (int i = 0; i < 50; i++) begin
      w.blk = 5'd0; w.off = i[6:0]; w.data = pkt[i];
      exp_wr.push_back(w);
    end
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hFE);
    for (int i = 0; i < 50; i++) send_byte(pkt[i]);
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_flags", {26'd0, bus.tx_valid, bus.wr_en, bus.blk_commit, busy, done, error}, 0);
    check("midrst_data", {4'd0, bus.tx_byte, bus.wr_block, bus.wr_byte, bus.wr_data}, 0);
    check("midrst_count", {26'd0, blk_count}, 0);
    check("midrst_wr_left", exp_wr.size(), 0);
    exp_wr.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // randomized sessions with mixed packet faults
    for (int t = 0; t < 3; t++) begin
      do_start();
      for (int k = 0; k < 6 && m_end == 0; k++) begin
        kind = $urandom_range(0, 9);
        b    = m_exp;
        bad  = 1'b0;
        case (kind)
          6:       bad = 1'b1;
          8:       b = m_exp - 8'd1;
          9:       b = m_exp + 8'd3;
          default: ;
        endcase
        nb = ~b;
        if (kind == 7) nb = nb ^ 8'h01;
        fill_pkt(1);
        send_packet(b, nb, bad, 1);
      end
      if (m_end == 0) send_eot();
      finish_check("random");
    end

    // slot overflow: the 33rd new block is cancelled
    do_start();
    for (int k = 1; k <= 33; k++) begin
      fill_pkt(1);
      b = 8'(k);
      send_packet(b, ~b, 0, 1);
    end
    finish_check("overflow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
